// File: rtl/line_pkg.sv
// Shared constants and state encoding for the terrain line renderer.
package line_pkg;

    localparam int LINE_W   = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic {
        RUN  = 1'b0,
        OVER = 1'b1
    } state_t;

endpackage : line_pkg

// File: rtl/line_hit_fsm.sv
// Game-state controller: counts grounded frames over a gap, tracks the
// survived-frame score and decides when the shadow line is reloaded.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | game live; each enabled frame start latches a line and scores
//   OVER  | player fell into a gap; everything frozen until restart
module line_hit_fsm
    import line_pkg::*;
#(
    parameter int GAP_LIMIT = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic        frame_start_i,
    input  logic        restart_i,
    input  logic        player_air_i,
    input  logic        ground_i,
    output logic        latch_o,
    output logic        reload_o,
    output logic        game_over_o,
    output logic [15:0] score_o
);

    localparam int            GW      = $clog2(GAP_LIMIT + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_LIMIT);

    state_t        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [GW-1:0] gap_inc;
    logic [15:0]   score_q, score_d;
    logic          game_over_q, game_over_d;

    // Next-state, counter and shadow-control decode.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        score_d   = score_q;
        latch_o   = 1'b0;
        reload_o  = 1'b0;
        gap_inc   = gap_cnt_q + GW'(1);

        case (state_q)
            RUN: begin
                if (frame_start_i && en_i) begin
                    latch_o = 1'b1;
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end
                    if (!player_air_i && !ground_i) begin
                        gap_cnt_d = gap_inc;
                        if (gap_inc == GAP_MAX) begin
                            state_d = OVER;
                        end
                    end else begin
                        gap_cnt_d = '0;
                    end
                end
            end
            OVER: begin
                // Restart wins over any frame start arriving in the same cycle.
                if (restart_i) begin
                    state_d   = RUN;
                    reload_o  = 1'b1;
                    score_d   = '0;
                    gap_cnt_d = '0;
                end
            end
            default: state_d = RUN;
        endcase

        game_over_d = (state_d == OVER);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            gap_cnt_q   <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
        end
    end

    assign game_over_o = game_over_q;
    assign score_o     = score_q;

endmodule : line_hit_fsm

// File: rtl/line_render.sv
// Ground-band renderer: holds a frame-coherent shadow of the terrain line
// and looks up lit pixels from it with one cycle of latency.
module line_render
    import line_pkg::*;
#(
    parameter int BAND_TOP  = 400,
    parameter int BAND_BOT  = 419,
    parameter int PLAYER_X  = 64,
    parameter int GAP_LIMIT = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              frame_start_i,
    input  logic              pix_valid_i,
    input  logic [9:0]        pix_x_i,
    input  logic [9:0]        pix_y_i,
    input  logic              player_air_i,
    input  logic              restart_i,
    output logic              pix_on_o,
    output logic              pix_valid_o,
    output logic              game_over_o,
    output logic [15:0]       score_o
);

    localparam logic [9:0] Y_TOP = 10'(BAND_TOP);
    localparam logic [9:0] Y_BOT = 10'(BAND_BOT);
    localparam logic [9:0] X_END = 10'(LINE_W);
    localparam logic [9:0] Y_END = 10'(SCREEN_H);

    logic [LINE_W-1:0] shadow_q, shadow_d;
    logic              pix_on_q, pix_on_d;
    logic              pix_valid_q, pix_valid_d;
    logic              latch;
    logic              reload;
    logic              x_in;
    logic              y_in;
    logic [9:0]        pix_idx;

    line_hit_fsm #(
        .GAP_LIMIT (GAP_LIMIT)
    ) u_hit_fsm (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .en_i          (en_i),
        .frame_start_i (frame_start_i),
        .restart_i     (restart_i),
        .player_air_i  (player_air_i),
        .ground_i      (line_i[PLAYER_X]),
        .latch_o       (latch),
        .reload_o      (reload),
        .game_over_o   (game_over_o),
        .score_o       (score_o)
    );

    // Shadow update and pixel lookup; lookup reads the pre-update shadow.
    always_comb begin
        shadow_d = shadow_q;
        if (reload) begin
            shadow_d = '1;
        end else if (latch) begin
            shadow_d = line_i;
        end

        x_in    = (pix_x_i < X_END);
        y_in    = (pix_y_i >= Y_TOP) && (pix_y_i <= Y_BOT) && (pix_y_i < Y_END);
        // Park the index at 0 off-line so the lookup never leaves the vector.
        pix_idx = x_in ? pix_x_i : 10'd0;

        pix_on_d    = pix_valid_i && x_in && y_in && shadow_q[pix_idx];
        pix_valid_d = pix_valid_i;
    end

    // Shadow register and pixel output pipeline stage.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_q    <= '1;
            pix_on_q    <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            pix_on_q    <= pix_on_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign pix_on_o    = pix_on_q;
    assign pix_valid_o = pix_valid_q;

endmodule : line_render

// File: tb/tb_line_render.sv
// Self-checking bench for line_render against a behavioural game model.
module tb_line_render;

    localparam int LW    = 640;
    localparam int TOP   = 400;
    localparam int BOT   = 419;
    localparam int PX    = 64;
    localparam int LIMIT = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic [LW-1:0]  line;
    logic           frame_start;
    logic           pix_valid;
    logic [9:0]     pix_x;
    logic [9:0]     pix_y;
    logic           air;
    logic           restart;
    logic           pix_on;
    logic           pix_valid_out;
    logic           game_over;
    logic [15:0]    score;

    // Behavioural model of what the screen and game should show.
    logic [LW-1:0]  m_shadow;
    int             m_score;
    int             m_gap;
    bit             m_over;
    bit             m_pix;
    bit             m_pv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    line_render dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .en_i          (en),
        .line_i        (line),
        .frame_start_i (frame_start),
        .pix_valid_i   (pix_valid),
        .pix_x_i       (pix_x),
        .pix_y_i       (pix_y),
        .player_air_i  (air),
        .restart_i     (restart),
        .pix_on_o      (pix_on),
        .pix_valid_o   (pix_valid_out),
        .game_over_o   (game_over),
        .score_o       (score)
    );

    // Advance one clock; the model follows the game rules for the inputs
    // present at the edge, then outputs are settled 1 time unit later.
    task automatic tick();
        int  x;
        int  y;
        bit  lit;
        @(posedge clk);
        x = int'(pix_x);
        y = int'(pix_y);
        if (reset) begin
            m_shadow = '1;
            m_score  = 0;
            m_gap    = 0;
            m_over   = 0;
            m_pix    = 0;
            m_pv     = 0;
        end else begin
            lit   = (x < LW) ? m_shadow[x] : 1'b0;
            m_pix = pix_valid && (y >= TOP) && (y <= BOT) && lit;
            m_pv  = pix_valid;
            if (!m_over) begin
                if (frame_start && en) begin
                    if (!air && !line[PX]) m_gap = m_gap + 1;
                    else                   m_gap = 0;
                    m_shadow = line;
                    if (m_score < 65535) m_score = m_score + 1;
                    if (m_gap == LIMIT) m_over = 1;
                end
            end else if (restart) begin
                m_over   = 0;
                m_shadow = '1;
                m_score  = 0;
                m_gap    = 0;
            end
        end
        #1;
    endtask

    task automatic set_pix(input int x, input int y);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        set_pix(100, 405);
        en = 1'b1;
        do_reset();
        n_tests++;
        if (score !== 16'd0 || game_over !== 1'b0 || pix_on !== 1'b0 || pix_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: score=%0d over=%b pix_on=%b pv=%b, required 0 0 0 0",
                     score, game_over, pix_on, pix_valid_out);
        end
        tick();
        n_tests++;
        if (pix_on !== 1'b1 || pix_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pix_405: pix_on=%b pv=%b, required 1 1", pix_on, pix_valid_out);
        end
        set_pix(100, 399);
        tick();
        n_tests++;
        if (pix_on !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pix_399: pix_on=%b, required 0", pix_on);
        end
    endtask

    task automatic test_frame_coherence();
        do_reset();
        set_pix(100, 405);
        for (int i = 0; i < 4; i++) begin
            line      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            line[100] = 1'b0;
            line[PX]  = 1'b1;
            tick();
            n_tests++;
            if (pix_on !== 1'b1) begin
                n_fail++;
                $display("FAIL coherence_mid_frame %0d: pix_on=%b, required 1", i, pix_on);
            end
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_tests++;
        if (pix_on !== 1'b1) begin
            n_fail++;
            $display("FAIL coherence_same_cycle: pix_on=%b, required 1 (pre-update shadow)", pix_on);
        end
        tick();
        n_tests++;
        if (pix_on !== 1'b0 || pix_on !== m_pix) begin
            n_fail++;
            $display("FAIL coherence_after_frame: pix_on=%b, required 0", pix_on);
        end
    endtask

    task automatic test_gap_limit();
        do_reset();
        line     = '1;
        line[PX] = 1'b0;
        air      = 1'b0;
        for (int i = 1; i <= LIMIT; i++) begin
            pulse_frame();
            n_tests++;
            if (game_over !== (i == LIMIT) || score !== 16'(i)) begin
                n_fail++;
                $display("FAIL gap_limit pulse %0d: over=%b score=%0d, required %b %0d",
                         i, game_over, score, (i == LIMIT), i);
            end
        end
        line = '0;
        pulse_frame();
        set_pix(200, 410);
        tick();
        n_tests++;
        if (game_over !== 1'b1 || score !== 16'd3 || pix_on !== 1'b1) begin
            n_fail++;
            $display("FAIL over_frozen: over=%b score=%0d pix_on=%b, required 1 3 1",
                     game_over, score, pix_on);
        end
    endtask

    task automatic test_gap_clear();
        bit airs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        line     = '1;
        line[PX] = 1'b0;
        foreach (airs[i]) begin
            air = airs[i];
            pulse_frame();
        end
        air = 1'b0;
        n_tests++;
        if (game_over !== 1'b0 || score !== 16'd5) begin
            n_fail++;
            $display("FAIL gap_clear: over=%b score=%0d, required 0 5", game_over, score);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_tests++;
        if (score !== 16'd5 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_in_run: over=%b score=%0d, required 0 5", game_over, score);
        end
    endtask

    task automatic test_enable_bounds();
        int xs [4]   = '{700, 639, 100, 1023};
        int ys [4]   = '{405, 419, 420, 405};
        bit exps [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        line = '0;
        pulse_frame();
        en   = 1'b0;
        line = '1;
        for (int i = 0; i < 4; i++) pulse_frame();
        n_tests++;
        if (score !== 16'd1) begin
            n_fail++;
            $display("FAIL enable_low: score=%0d, required 1", score);
        end
        en = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_pix(xs[i], ys[i]);
            tick();
            n_tests++;
            if (pix_on !== exps[i]) begin
                n_fail++;
                $display("FAIL pix_bounds (%0d,%0d): pix_on=%b, required %b",
                         xs[i], ys[i], pix_on, exps[i]);
            end
        end
    endtask

    task automatic test_restart_priority();
        do_reset();
        line = '0;
        air  = 1'b0;
        for (int i = 0; i < LIMIT; i++) pulse_frame();
        n_tests++;
        if (game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_setup: over=%b, required 1", game_over);
        end
        set_pix(100, 405);
        restart     = 1'b1;
        frame_start = 1'b1;
        tick();
        restart     = 1'b0;
        frame_start = 1'b0;
        tick();
        n_tests++;
        if (game_over !== 1'b0 || score !== 16'd0 || pix_on !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_priority: over=%b score=%0d pix_on=%b, required 0 0 1",
                     game_over, score, pix_on);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            en          = ($urandom_range(0, 7) != 0);
            frame_start = ($urandom_range(0, 5) == 0);
            restart     = ($urandom_range(0, 9) == 0);
            air         = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                line     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                line[PX] = ($urandom_range(0, 2) == 0);
            end
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_x     = 10'($urandom_range(0, 1023));
            pix_y     = 10'($urandom_range(390, 430));
            tick();
            n_tests++;
            if (pix_on !== m_pix || pix_valid_out !== m_pv || game_over !== m_over ||
                score !== 16'(m_score)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d: pix_on=%b pv=%b over=%b score=%0d, required %b %b %b %0d",
                             c, pix_on, pix_valid_out, game_over, score, m_pix, m_pv, m_over, m_score);
            end
        end
        reset       = 1'b0;
        frame_start = 1'b0;
        restart     = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        en          = 1'b1;
        line        = '1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        air         = 1'b0;
        restart     = 1'b0;
        m_shadow    = '1;
        m_score     = 0;
        m_gap       = 0;
        m_over      = 0;
        m_pix       = 0;
        m_pv        = 0;
        #2;
        test_reset();
        test_frame_coherence();
        test_gap_limit();
        test_gap_clear();
        test_enable_bounds();
        test_restart_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_line_render
